ahb_req_sequencer: RTL and testbench

AHB_REQ_SEQUENCER -- requirements
Module: ahb_req_sequencer

---
 rtl/ahb_req_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_ahb_req_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ahb_req_sequencer
// Purpose  : Queues host commands and issues them one at a time to an AHB
//            system, returning the read data, error and timeout status.
// Revision : 1.0
// ============================================================================
module ahb_req_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SLAVE_NUM    = 4,
  parameter int HBURST_WIDTH = 3,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                         HCLK,
  input  logic                         HRST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [$clog2(SLAVE_NUM)-1:0] cmd_sel,
  input  logic [2:0]                   cmd_size,
  input  logic [HBURST_WIDTH-1:0]      cmd_burst,
  input  logic [DATA_WIDTH-1:0]        cmd_wdata,
  output logic [$clog2(DEPTH):0]       cmd_count,
  output logic                         sys_enable,
  output logic [DATA_WIDTH-1:0]        sys_wdata,
  output logic [ADDR_WIDTH-1:0]        sys_addr,
  output logic [$clog2(SLAVE_NUM)-1:0] sys_sel,
  output logic [2:0]                   sys_size,
  output logic                         sys_write,
  output logic [HBURST_WIDTH-1:0]      sys_burst,
  input  logic [DATA_WIDTH-1:0]        sys_rdata,
  input  logic                         sys_readyout,
  input  logic                         sys_resp,
  output logic                         rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic                         busy
);

  localparam int c_SEL_W = $clog2(SLAVE_NUM);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ENT_W = 1 + ADDR_WIDTH + c_SEL_W + 3 + HBURST_WIDTH + DATA_WIDTH;
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
  localparam logic [7:0]         c_WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [c_ENT_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [7:0]         r_wait;

  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_ready_hit;
  logic w_timeout_hit;

  logic                    w_h_write;
  logic [ADDR_WIDTH-1:0]   w_h_addr;
  logic [c_SEL_W-1:0]      w_h_sel;
  logic [2:0]              w_h_size;
  logic [HBURST_WIDTH-1:0] w_h_burst;
  logic [DATA_WIDTH-1:0]   w_h_wdata;

  assign cmd_ready  = (r_count != c_FULL);
  assign cmd_count  = r_count;
  assign w_push     = cmd_valid && cmd_ready;
  assign sys_enable = (r_state == S_ISSUE);
  assign rsp_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);

  assign {w_h_write, w_h_addr, w_h_sel, w_h_size, w_h_burst, w_h_wdata} = r_mem[r_rd_ptr];

  // --------------------------------------------------------------------------
  // Command queue
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRST && w_push) begin
      r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_sel, cmd_size, cmd_burst, cmd_wdata};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_load        = 1'b0;
    w_ready_hit   = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load       = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // A ready in the final allowed wait cycle still completes normally.
        if (sys_readyout) begin
          w_ready_hit  = 1'b1;
          w_pop        = 1'b1;
          w_state_next = S_DONE;
        end else if (r_wait == c_WAIT_LAST) begin
          w_timeout_hit = 1'b1;
          w_pop         = 1'b1;
          w_state_next  = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // System-side drive, wait counter and response capture
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      sys_write   <= 1'b0;
      sys_addr    <= '0;
      sys_sel     <= '0;
      sys_size    <= '0;
      sys_burst   <= '0;
      sys_wdata   <= '0;
      r_wait      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // The head entry is stable while its transfer is outstanding, so a
      // single load on the way into ISSUE covers the whole transfer.
      if (w_load) begin
        sys_write <= w_h_write;
        sys_addr  <= w_h_addr;
        sys_sel   <= w_h_sel;
        sys_size  <= w_h_size;
        sys_burst <= w_h_burst;
        sys_wdata <= w_h_wdata;
      end

      if (r_state == S_ISSUE) begin
        r_wait <= '0;
      end else if ((r_state == S_WAIT) && !sys_readyout) begin
        r_wait <= r_wait + 8'd1;
      end

      if (w_ready_hit) begin
        rsp_rdata   <= sys_rdata;
        rsp_err     <= sys_resp;
        rsp_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_req_sequencer.sv
`default_nettype none
// Testbench for ahb_req_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level queue model.
module tb_ahb_req_sequencer;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SN      = 4;
  localparam int SW      = 2;
  localparam int HB      = 3;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;
  localparam int CW      = 3;

  logic          HCLK = 1'b0;
  logic          HRST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [SW-1:0] cmd_sel;
  logic [2:0]    cmd_size;
  logic [HB-1:0] cmd_burst;
  logic [DW-1:0] cmd_wdata;
  logic [CW-1:0] cmd_count;
  logic          sys_enable;
  logic [DW-1:0] sys_wdata;
  logic [AW-1:0] sys_addr;
  logic [SW-1:0] sys_sel;
  logic [2:0]    sys_size;
  logic          sys_write;
  logic [HB-1:0] sys_burst;
  logic [DW-1:0] sys_rdata;
  logic          sys_readyout;
  logic          sys_resp;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;

  ahb_req_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVE_NUM(SN), .HBURST_WIDTH(HB),
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .HCLK(HCLK), .HRST(HRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .cmd_wdata(cmd_wdata), .cmd_count(cmd_count),
    .sys_enable(sys_enable), .sys_wdata(sys_wdata), .sys_addr(sys_addr),
    .sys_sel(sys_sel), .sys_size(sys_size), .sys_write(sys_write),
    .sys_burst(sys_burst), .sys_rdata(sys_rdata), .sys_readyout(sys_readyout),
    .sys_resp(sys_resp), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  always @(posedge HCLK) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
    logic [2:0]    size;
    logic [HB-1:0] burst;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t          q[$];
  cmd_t          m_sys;
  bit            m_ok   = 0;
  bit            m_xfer = 0;
  int            m_issue = 0;
  int            m_done  = -1;
  int            m_cyc   = 0;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic          m_to;

  // Transfer timing is tracked as timestamps: ISSUE is the cycle after launch,
  // wait cycles follow it, DONE is the cycle after completion.
  always @(negedge HCLK) begin : model
    cmd_t c;
    bit   push;
    bit   pop;
    m_cyc++;
    if (m_ok) begin
      chk("cmd_count",   cmd_count,   q.size());
      chk("cmd_ready",   cmd_ready,   q.size() != DEPTH);
      chk("sys_enable",  sys_enable,  m_xfer && (m_cyc == m_issue));
      chk("rsp_valid",   rsp_valid,   m_cyc == m_done);
      chk("busy",        busy,        m_xfer || (m_cyc == m_done));
      chk("sys_addr",    sys_addr,    m_sys.addr);
      chk("sys_sel",     sys_sel,     m_sys.sel);
      chk("sys_size",    sys_size,    m_sys.size);
      chk("sys_burst",   sys_burst,   m_sys.burst);
      chk("sys_write",   sys_write,   m_sys.wr);
      chk("sys_wdata",   sys_wdata,   m_sys.wdata);
      chk("rsp_rdata",   rsp_rdata,   m_rdata);
      chk("rsp_err",     rsp_err,     m_err);
      chk("rsp_timeout", rsp_timeout, m_to);
    end
    if (HRST) begin
      q.delete();
      m_xfer = 0;
      m_done = -1;
      m_sys.wr = 0; m_sys.addr = '0; m_sys.sel = '0;
      m_sys.size = '0; m_sys.burst = '0; m_sys.wdata = '0;
      m_rdata = '0; m_err = 0; m_to = 0;
      m_ok = 1;
    end else if (m_ok) begin
      push = cmd_valid && (q.size() != DEPTH);
      pop  = 0;
      if (m_xfer && (m_cyc > m_issue)) begin
        if (sys_readyout) begin
          m_rdata = sys_rdata; m_err = sys_resp; m_to = 0; pop = 1;
        end else if (m_cyc - m_issue == TIMEOUT) begin
          m_rdata = '0; m_err = 1; m_to = 1; pop = 1;
        end
        if (pop) begin
          m_xfer = 0;
          m_done = m_cyc + 1;
          void'(q.pop_front());
        end
      end else if (!m_xfer && (m_cyc != m_done) && (q.size() != 0)) begin
        m_xfer  = 1;
        m_issue = m_cyc + 1;
        m_sys   = q[0];
      end
      if (push) begin
        c.wr = cmd_write; c.addr = cmd_addr; c.sel = cmd_sel;
        c.size = cmd_size; c.burst = cmd_burst; c.wdata = cmd_wdata;
        q.push_back(c);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_cmd(input bit wr, input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input logic [DW-1:0] d);
    cmd_write = wr; cmd_addr = a; cmd_sel = s; cmd_size = 3'd2; cmd_burst = '0; cmd_wdata = d;
  endtask

  task automatic push_cmd(input bit wr, input logic [AW-1:0] a, input logic [SW-1:0] s,
                          input logic [DW-1:0] d);
    set_cmd(wr, a, s, d);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // which: 0 = sys_enable, 1 = rsp_valid, 2 = idle and empty
  task automatic wait_sig(input string name, input int which, output int t);
    bit hit;
    hit = 0;
    t = -1;
    for (int i = 0; i < 60; i++) begin
      case (which)
        0:       hit = (sys_enable === 1'b1);
        1:       hit = (rsp_valid === 1'b1);
        default: hit = (busy === 1'b0) && (cmd_count === '0);
      endcase
      if (hit) begin
        t = tb_cyc;
        break;
      end
      tick();
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: event not seen within 60 cycles", name);
    end
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int t0, t1, t2, tn;
    logic [AW-1:0] addrs [3];
    int rt [3];
    int na, nr;

    HRST = 1'b1; cmd_valid = 1'b0;
    set_cmd(0, '0, '0, '0);
    sys_rdata = '0; sys_readyout = 1'b0; sys_resp = 1'b0;
    repeat (3) tick();
    HRST = 1'b0;

    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset cmd_count", cmd_count, 0);
    chk("reset busy",      busy,      0);
    chk("reset sys_addr",  sys_addr,  0);

    // single read with two wait cycles
    push_cmd(0, 32'h10, 2'd2, '0);
    wait_sig("read issue", 0, t0);
    chk("read sys_sel",   sys_sel,   2);
    chk("read sys_addr",  sys_addr,  32'h10);
    chk("read sys_write", sys_write, 0);
    repeat (3) tick();
    sys_readyout = 1'b1; sys_rdata = 32'hDEADBEEF; sys_resp = 1'b0;
    tick();
    sys_readyout = 1'b0;
    chk("read rsp_valid", rsp_valid, 1);
    chk("read latency",   tb_cyc - t0, 4);
    chk("read rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("read rsp_err",   rsp_err,   0);
    tick();

    // queue full: the fifth command waits for the first completion
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1, AW'(32'h100 + 4 * i), 2'd1, DW'(i));
      tick();
    end
    chk("full cmd_count", cmd_count, 4);
    chk("full cmd_ready", cmd_ready, 0);
    set_cmd(1, 32'h110, 2'd1, 32'h5);
    tn = -1;
    for (int i = 0; i < 30; i++) begin
      if (cmd_ready) begin
        tn = i;
        break;
      end
      tick();
    end
    chk("fifth waits for completion", rsp_valid, 1);
    chk("fifth ready count", cmd_count, 3);
    tick();
    cmd_valid = 1'b0;
    sys_readyout = 1'b1;
    wait_sig("full drain", 2, t0);
    sys_readyout = 1'b0;
    tick();

    // ordering with ready always high
    sys_readyout = 1'b1;
    na = 0; nr = 0; t0 = tb_cyc;
    for (int i = 0; i < 3; i++) begin addrs[i] = '1; rt[i] = -100; end
    for (int k = 0; k < 30; k++) begin
      if (k < 3) begin
        set_cmd(1, AW'(4 * k), 2'd0, DW'(k));
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      if (sys_enable && na < 3) begin addrs[na] = sys_addr; na++; end
      if (rsp_valid && nr < 3) begin rt[nr] = tb_cyc; nr++; end
      tick();
    end
    sys_readyout = 1'b0;
    chk("order addr0", addrs[0], 32'h0);
    chk("order addr1", addrs[1], 32'h4);
    chk("order addr2", addrs[2], 32'h8);
    chk("order min latency", rt[0] - (t0 + 1), 3);
    // DONE, IDLE, ISSUE, WAIT: three idle cycles between successive pulses
    chk("order spacing 01", rt[1] - rt[0], 4);
    chk("order spacing 12", rt[2] - rt[1], 4);

    // error response
    sys_readyout = 1'b1; sys_resp = 1'b1; sys_rdata = 32'hCAFE0001;
    push_cmd(0, 32'h40, 2'd3, '0);
    wait_sig("err rsp", 1, t0);
    chk("err rsp_err",     rsp_err,     1);
    chk("err rsp_timeout", rsp_timeout, 0);
    sys_readyout = 1'b0; sys_resp = 1'b0;
    tick();

    // timeout, then the next queued command issues
    sys_rdata = 32'h12345678;
    cmd_valid = 1'b1;
    set_cmd(0, 32'h200, 2'd1, '0); tick();
    set_cmd(0, 32'h204, 2'd2, '0); tick();
    cmd_valid = 1'b0;
    wait_sig("to issue", 0, t0);
    wait_sig("to rsp", 1, t1);
    chk("to latency",     t1 - t0, TIMEOUT + 1);
    chk("to rsp_err",     rsp_err,     1);
    chk("to rsp_timeout", rsp_timeout, 1);
    chk("to rsp_rdata",   rsp_rdata,   0);
    wait_sig("to next issue", 0, t2);
    chk("to next gap",  t2 - t1, 2);
    chk("to next addr", sys_addr, 32'h204);
    wait_sig("to drain", 2, t0);

    // reset while a transfer waits with another queued
    cmd_valid = 1'b1;
    set_cmd(1, 32'h300, 2'd0, 32'h1); tick();
    set_cmd(1, 32'h304, 2'd0, 32'h2); tick();
    tick();
    chk("rst-wait busy before", busy, 1);
    HRST = 1'b1;
    set_cmd(1, 32'h308, 2'd0, 32'h3);
    tick();
    HRST = 1'b0; cmd_valid = 1'b0;
    chk("rst-wait cmd_count", cmd_count, 0);
    chk("rst-wait busy",      busy,      0);
    chk("rst-wait sys_addr",  sys_addr,  0);
    for (int i = 0; i < 6; i++) begin
      chk("rst-wait no rsp_valid", rsp_valid, 0);
      tick();
    end

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      HRST         = ($urandom_range(0, 499) == 0);
      cmd_valid    = ($urandom_range(0, 99) < 40);
      cmd_write    = $urandom_range(0, 1);
      cmd_addr     = $urandom;
      cmd_sel      = SW'($urandom_range(0, SN - 1));
      cmd_size     = 3'($urandom_range(0, 7));
      cmd_burst    = HB'($urandom_range(0, 7));
      cmd_wdata    = $urandom;
      sys_readyout = ($urandom_range(0, 99) < 35);
      sys_resp     = ($urandom_range(0, 3) == 0);
      sys_rdata    = $urandom;
      tick();
    end
    HRST = 1'b0; cmd_valid = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
